// File: rtl/mult_test_ctrl_pkg.sv
// Shared types and defaults for the multiplier test sequencer.
package mult_test_ctrl_pkg;

  // Sequencer states; the encoding is shown directly on the stage LEDs.
  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CALC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LATENCY = 4;

endpackage

// File: rtl/mult_test_ctrl_btn_edge.sv
// Raw push-button sampler: three-deep history, one-cycle pulse on a rising edge.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic [2:0] hist_q;
  logic [2:0] hist_d;

  // Shift the raw level in; the first stage doubles as a metastability guard.
  always_comb begin
    hist_d = {hist_q[1:0], in};
  end

  // History register, cleared so a button held through reset does not fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 3'b000;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Pulse only on the 0->1 transition, so a held button fires once.
  assign pulse = hist_q[1] & ~hist_q[2];

endmodule

// File: rtl/mult_test_ctrl.sv
// Operator sequencer: enter A, enter B, wait for the multiplier, show the product.
module mult_test_ctrl
  import mult_test_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic                 btn_clear,
  input  logic [WIDTH-1:0]     sw,
  input  logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           stage,
  output logic                 busy,
  output logic                 result_valid
);

  localparam int               CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  logic next_p;
  logic clear_p;

  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0]   op_a_q,   op_a_d;
  logic [WIDTH-1:0]   op_b_q,   op_b_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  btn_edge u_next_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_next),
    .pulse (next_p)
  );

  btn_edge u_clear_edge (
    .clk   (clk),
    .rst   (rst),
    .in    (btn_clear),
    .pulse (clear_p)
  );

  // Next-state logic; clear wins over next, and next is ignored while computing.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    if (clear_p) begin
      state_d  = S_A;
      cnt_d    = '0;
      op_a_d   = '0;
      op_b_d   = '0;
      result_d = '0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (next_p) begin
            op_a_d  = sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (next_p) begin
            op_b_d  = sw;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          // Operands have been stable for LATENCY cycles on the capture edge.
          if (cnt_q == CNT_LAST) begin
            result_d = product;
            state_d  = S_SHOW;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_SHOW: begin
          if (next_p) begin
            state_d = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  // State, counter and operand/result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_A;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign result       = result_q;
  assign stage        = state_q;
  assign busy         = (state_q == S_CALC);
  assign result_valid = (state_q == S_SHOW);

endmodule

// File: tb/tb_mult_test_ctrl.sv
// Bench for mult_test_ctrl: directed operator sequences, scoreboard on result_valid.
module tb_mult_test_ctrl;

  localparam int WIDTH   = 8;
  localparam int LATENCY = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 btn_next = 1'b0;
  logic                 btn_clear = 1'b0;
  logic [WIDTH-1:0]     sw = '0;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   result;
  logic [1:0]           stage;
  logic                 busy;
  logic                 result_valid;

  int n_vec = 0;
  int n_err = 0;

  // Expected products, pushed when a computation is launched.
  logic [2*WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  mult_test_ctrl #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_next     (btn_next),
    .btn_clear    (btn_clear),
    .sw           (sw),
    .product      (product),
    .op_a         (op_a),
    .op_b         (op_b),
    .result       (result),
    .stage        (stage),
    .busy         (busy),
    .result_valid (result_valid)
  );

  // Multiplier model: product settles LATENCY-1 edges after operands change,
  // so a capture one cycle early sees a stale value.
  logic [2*WIDTH-1:0] pipe [0:LATENCY-2];
  always @(posedge clk) begin
    pipe[0] <= 16'(op_a) * 16'(op_b);
    for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign product = pipe[LATENCY-2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on each result_valid rise, pop the scoreboard and check busy length.
  initial begin : monitor
    logic prev_rv;
    logic prev_busy;
    int   busy_cnt;
    logic [2*WIDTH-1:0] e;
    prev_rv   = 1'b0;
    prev_busy = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (busy) busy_cnt = prev_busy ? busy_cnt + 1 : 1;
      if (result_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          check("unexpected_capture", 32'(result_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", 32'(result), 32'(e));
          check("busy_cycles", 32'(busy_cnt), 32'(LATENCY));
          $display("result %04h (expected %04h), busy %0d cycles", result, e, busy_cnt);
        end
      end
      prev_rv   = result_valid;
      prev_busy = busy;
    end
  end

  // Press next with the switches set, hold 3 cycles, release; FSM has acted on return.
  task automatic press_next(input logic [WIDTH-1:0] v);
    @(negedge clk);
    sw = v;
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Bounded wait for the show state.
  task automatic wait_show();
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_show_timeout", 32'(result_valid), 32'd1);
  endtask

  initial begin : stim
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stage", 32'(stage), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full sequence 0x0C * 0x0F = 0x00B4
    press_next(8'h0C);
    check("seq_stage_b", 32'(stage), 32'd1);
    check("seq_op_a", 32'(op_a), 32'h0C);
    exp_q.push_back(16'h00B4);
    press_next(8'h0F);
    wait_show();
    check("seq_stage_show", 32'(stage), 32'd3);
    check("seq_op_a_hold", 32'(op_a), 32'h0C);
    check("seq_op_b", 32'(op_b), 32'h0F);
    check("seq_result", 32'(result), 32'h00B4);

    // Wrap back to S_A; result held
    press_next(8'h55);
    check("wrap_stage", 32'(stage), 32'd0);
    check("wrap_result_held", 32'(result), 32'h00B4);
    check("wrap_valid", 32'(result_valid), 32'd0);

    // Held button: single advance, acts on the second edge after first sample
    @(negedge clk);
    sw = 8'h07;
    btn_next = 1'b1;
    @(negedge clk);
    check("held_lat_e0", 32'(stage), 32'd0);
    @(negedge clk);
    check("held_lat_e1", 32'(stage), 32'd0);
    @(negedge clk);
    check("held_lat_e2", 32'(stage), 32'd1);
    check("held_op_a", 32'(op_a), 32'h07);
    repeat (47) @(negedge clk);
    check("held_one_advance", 32'(stage), 32'd1);
    btn_next = 1'b0;
    repeat (3) @(negedge clk);

    // Second next pulse lands two edges into S_CALC and must be ignored
    exp_q.push_back(16'h003F);
    @(negedge clk);
    sw = 8'h09;
    btn_next = 1'b1;
    @(negedge clk);
    btn_next = 1'b0;
    @(negedge clk);
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    wait_show();
    repeat (4) @(negedge clk);
    check("calc_ign_stage", 32'(stage), 32'd3);
    check("calc_ign_op_b", 32'(op_b), 32'h09);
    check("calc_ign_result", 32'(result), 32'h003F);

    // Back to S_A, into S_B, then next+clear together
    press_next(8'h00);
    check("show_to_a_result", 32'(result), 32'h003F);
    press_next(8'h11);
    check("clr_pre_stage", 32'(stage), 32'd1);
    @(negedge clk);
    sw = 8'h22;
    btn_next = 1'b1;
    btn_clear = 1'b1;
    repeat (3) @(negedge clk);
    btn_next = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("clr_stage", 32'(stage), 32'd0);
    check("clr_op_a", 32'(op_a), 32'd0);
    check("clr_op_b", 32'(op_b), 32'd0);
    check("clr_result", 32'(result), 32'd0);

    // Asynchronous reset in the middle of S_CALC
    press_next(8'h02);
    @(negedge clk);
    sw = 8'h03;
    btn_next = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd1);
    btn_next = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("abort_stage", 32'(stage), 32'd0);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_op_a", 32'(op_a), 32'd0);
    check("abort_op_b", 32'(op_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_capture", 32'(result), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_stage_after", 32'(stage), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_test_ctrl.md
# mult_test_ctrl

Board-level sequencer for exercising the carry-save multiplier from switches and two push-buttons. Edge-detects the raw buttons, steps operator entry (operand A, operand B), launches the multiplier, waits a fixed settling latency, then latches and holds the product for display. Sits between the board I/O (switches, buttons, LEDs/7-seg driver) and the multiplier datapath.

## Interface
- WIDTH, 8, operand width in bits; product is 2*WIDTH.
- LATENCY, 4, clk cycles from operands stable to product valid; legal range ≥1.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_next  in  1  raw "advance" button, active-high, unsynchronised
- btn_clear  in  1  raw "clear" button, active-high, unsynchronised
- sw  in  WIDTH  operand switches
- product  in  2*WIDTH  multiplier output
- op_a  out  WIDTH  multiplier operand A (registered)
- op_b  out  WIDTH  multiplier operand B (registered)
- result  out  2*WIDTH  captured product (registered)
- stage  out  2  current state encoding, for LEDs
- busy  out  1  high in S_CALC
- result_valid  out  1  high in S_SHOW

## Operation
- States (stage encoding): S_A=0, S_B=1, S_CALC=2, S_SHOW=3.
- Each button passes through its own edge detector → one-cycle pulses next_p, clear_p.
- S_A: next_p → op_a<=sw, go S_B.
- S_B: next_p → op_b<=sw, cnt<=0, go S_CALC.
- S_CALC: next_p ignored; cnt increments each cycle; at cnt==LATENCY-1 → result<=product, go S_SHOW. Exactly LATENCY cycles spent in S_CALC.
- S_SHOW: next_p → go S_A; op_a, op_b, result held until overwritten.
- clear_p in any state → op_a, op_b, result, cnt <= 0, go S_A. clear_p has priority over next_p in the same cycle.
- sw changes outside the capture cycle have no effect on outputs.
- cnt width $clog2(LATENCY+1); no wrap in normal use (reset on S_CALC entry).
- Reset values: op_a=0, op_b=0, result=0, stage=S_A(0), busy=0, result_valid=0, cnt=0, edge-detector history=0.
- Reset mid-S_CALC aborts: no capture, state S_A, all outputs at reset values.

## Timing
- Edge detector: 3-bit shift history per button; pulse = history[1] & ~history[2]. Raw high first sampled at edge k → pulse high in the cycle after edge k+1 → FSM acts at edge k+2. Button held high gives one pulse only; release-and-press again needed.
- Capture: op_a/op_b update on the same edge as the state change.
- S_B→S_CALC at edge t; result updated and result_valid rises at edge t+LATENCY.
- busy, result_valid, stage are decoded from state register (no extra latency).

## Structure
- Shared package: state enum (S_A..S_SHOW, 2-bit), default WIDTH/LATENCY constants.
- One sub-module: btn_edge (clk, rst, in, pulse) — 3-stage sampler + rising-edge detect, instantiated twice.
- FSM, counter, operand/result registers in the top module.

## Test plan
- Reset: assert rst mid-run in S_CALC → all outputs 0, stage=0 immediately (asynchronous), no result capture after release.
- Full sequence, WIDTH=8, LATENCY=4: sw=0x0C, press next; sw=0x0F, press next → op_a=0x0C, op_b=0x0F, busy high exactly 4 cycles, result=0x00B4, stage=3, result_valid=1.
- Held button: btn_next high for 50 cycles in S_A → exactly one advance (stage 0→1), pulse appears 2 edges after first sample.
- next during S_CALC: press next while busy → ignored, still S_SHOW after LATENCY cycles, result correct.
- Simultaneous next+clear pulses in S_B → stage=0, op_a=op_b=result=0.
- Wrap: from S_SHOW press next → stage=0, old result still 0x00B4 until next computation overwrites it.
